// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file -- machine-mode CSR register file for the single-cycle core.
//
// Responds to the decoder's csr_rd/csr_wr strobes for Zicsr read-modify-write
// instructions, runs the free-running 64-bit mcycle counter, takes the machine
// timer interrupt and executes mret. Reads and redirects are combinational;
// every state change lands on the posedge that ends the current cycle.
//
// Ports:
//   clk        core clock
//   rst_n      synchronous active-low reset
//   csr_rd     current instruction reads a CSR
//   csr_wr     current instruction may write a CSR
//   inst       current instruction ([31:20] csr addr, [19:15] rs1/zimm,
//              [14:12] func3)
//   rs1_data   register-file rs1 value
//   pc         PC of the instruction executing this cycle
//   timer_irq  level machine timer interrupt request
//   is_mret    current instruction is mret
//   csr_rdata  pre-update value of the addressed CSR (0 when not reading)
//   epc_taken  redirect fetch this cycle
//   epc        redirect target
// ---------------------------------------------------------------------------
module csr_file #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_rd,
  input  logic            csr_wr,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] pc,
  input  logic            timer_irq,
  input  logic            is_mret,
  output logic [XLEN-1:0] csr_rdata,
  output logic            epc_taken,
  output logic [XLEN-1:0] epc
);

  // CSR addresses
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

  // Bit positions inside the status/enable/pending words
  localparam int unsigned BIT_MIE  = 3;
  localparam int unsigned BIT_MPIE = 7;
  localparam int unsigned BIT_MTIE = 7;

  // Machine timer interrupt: cause code and vectored-mode offset (4 * 7)
  localparam logic [31:0] MCAUSE_MTI     = 32'h8000_0007;
  localparam logic [31:0] VEC_MTI_OFFSET = 32'd28;

  // Zicsr RMW operation encoded in func3[1:0]; 2'b00 means no write
  function automatic logic [XLEN-1:0] csr_rmw(
    input logic [1:0]      op,
    input logic [XLEN-1:0] old_val,
    input logic [XLEN-1:0] src
  );
    logic [XLEN-1:0] res;
    case (op)
      2'b01:   res = src;
      2'b10:   res = old_val | src;
      2'b11:   res = old_val & ~src;
      default: res = old_val;
    endcase
    return res;
  endfunction

  // mstatus is stored as two flops; this rebuilds the architectural word
  function automatic logic [XLEN-1:0] pack_mstatus(
    input logic mie_bit,
    input logic mpie_bit
  );
    logic [XLEN-1:0] word;
    word           = {XLEN{1'b0}};
    word[BIT_MIE]  = mie_bit;
    word[BIT_MPIE] = mpie_bit;
    return word;
  endfunction

  // Instruction fields
  logic [11:0] csr_addr_s;
  logic [4:0]  zimm_s;
  logic [2:0]  func3_s;

  assign csr_addr_s = inst[31:20];
  assign zimm_s     = inst[19:15];
  assign func3_s    = inst[14:12];

  // Architectural state
  logic            mstatus_mie_r;
  logic            mstatus_mpie_r;
  logic            mie_mtie_r;
  logic [XLEN-1:0] mtvec_r;
  logic [XLEN-1:0] mscratch_r;
  logic [XLEN-1:2] mepc_r;      // low two bits are hard-wired to zero
  logic [XLEN-1:0] mcause_r;
  logic [XLEN-1:0] mcycle_lo_r;
  logic [XLEN-1:0] mcycle_hi_r;

  // Combinational helpers
  logic            irq_s;
  logic            mret_s;
  logic [XLEN-1:0] old_s;
  logic [XLEN-1:0] src_s;
  logic [XLEN-1:0] wdata_s;
  logic            wr_op_s;
  logic            commit_s;
  logic            we_mstatus_s;
  logic            we_mie_s;
  logic            we_mtvec_s;
  logic            we_mscratch_s;
  logic            we_mepc_s;
  logic            we_mcause_s;
  logic            we_mcycle_s;
  logic            we_mcycleh_s;
  logic [XLEN-1:0] trap_base_s;
  logic [XLEN-1:0] trap_target_s;
  logic [XLEN-1:0] mcycle_lo_next_s;
  logic [XLEN-1:0] mcycle_hi_next_s;
  logic            mcycle_carry_s;

  // Bits of the inputs this block has no use for (opcode/rd, pc alignment)
  logic unused_bits_s;
  assign unused_bits_s = ^{inst[11:0], pc[1:0]};

  // Interrupt wins over mret; a trapping cycle also suppresses the CSR write
  assign irq_s  = timer_irq & mstatus_mie_r & mie_mtie_r;
  assign mret_s = is_mret & ~irq_s;

  // Read mux: value of the addressed CSR before this cycle's update
  always_comb begin
    old_s = {XLEN{1'b0}};
    case (csr_addr_s)
      ADDR_MSTATUS:  old_s = pack_mstatus(mstatus_mie_r, mstatus_mpie_r);
      ADDR_MIE:      old_s = {{(XLEN-1-BIT_MTIE){1'b0}}, mie_mtie_r, {BIT_MTIE{1'b0}}};
      ADDR_MTVEC:    old_s = mtvec_r;
      ADDR_MSCRATCH: old_s = mscratch_r;
      ADDR_MEPC:     old_s = {mepc_r, 2'b00};
      ADDR_MCAUSE:   old_s = mcause_r;
      ADDR_MIP:      old_s = {{(XLEN-1-BIT_MTIE){1'b0}}, timer_irq, {BIT_MTIE{1'b0}}};
      ADDR_MCYCLE:   old_s = mcycle_lo_r;
      ADDR_MCYCLEH:  old_s = mcycle_hi_r;
      default:       old_s = {XLEN{1'b0}};
    endcase
  end

  assign csr_rdata = csr_rd ? old_s : {XLEN{1'b0}};

  // Write decode: operand select, RMW result and whether a write happens.
  // RS/RC with a zero rs1/zimm field are pure reads.
  always_comb begin
    src_s   = func3_s[2] ? {{(XLEN-5){1'b0}}, zimm_s} : rs1_data;
    wdata_s = csr_rmw(func3_s[1:0], old_s, src_s);
    wr_op_s = 1'b0;
    case (func3_s[1:0])
      2'b01:   wr_op_s = 1'b1;
      2'b10:   wr_op_s = (zimm_s != 5'd0);
      2'b11:   wr_op_s = (zimm_s != 5'd0);
      default: wr_op_s = 1'b0;
    endcase
  end

  assign commit_s      = csr_wr & wr_op_s & ~irq_s & ~mret_s;
  assign we_mstatus_s  = commit_s & (csr_addr_s == ADDR_MSTATUS);
  assign we_mie_s      = commit_s & (csr_addr_s == ADDR_MIE);
  assign we_mtvec_s    = commit_s & (csr_addr_s == ADDR_MTVEC);
  assign we_mscratch_s = commit_s & (csr_addr_s == ADDR_MSCRATCH);
  assign we_mepc_s     = commit_s & (csr_addr_s == ADDR_MEPC);
  assign we_mcause_s   = commit_s & (csr_addr_s == ADDR_MCAUSE);
  assign we_mcycle_s   = commit_s & (csr_addr_s == ADDR_MCYCLE);
  assign we_mcycleh_s  = commit_s & (csr_addr_s == ADDR_MCYCLEH);

  // Trap vector: mode 01 is vectored, every other mode value is direct
  always_comb begin
    trap_base_s = {mtvec_r[XLEN-1:2], 2'b00};
    if (mtvec_r[1:0] == 2'b01) begin
      trap_target_s = trap_base_s + VEC_MTI_OFFSET;
    end else begin
      trap_target_s = trap_base_s;
    end
  end

  // Fetch redirect for interrupt entry or mret
  always_comb begin
    epc_taken = 1'b0;
    epc       = {XLEN{1'b0}};
    if (irq_s) begin
      epc_taken = 1'b1;
      epc       = trap_target_s;
    end else if (mret_s) begin
      epc_taken = 1'b1;
      epc       = {mepc_r, 2'b00};
    end else begin
      epc_taken = 1'b0;
      epc       = {XLEN{1'b0}};
    end
  end

  // mcycle next value: a written half takes the write data, the other half
  // keeps counting (the high half still sees the carry out of the old low half)
  always_comb begin
    mcycle_carry_s = &mcycle_lo_r;
    if (we_mcycle_s) begin
      mcycle_lo_next_s = wdata_s;
    end else begin
      mcycle_lo_next_s = mcycle_lo_r + 32'd1;
    end
    if (we_mcycleh_s) begin
      mcycle_hi_next_s = wdata_s;
    end else begin
      mcycle_hi_next_s = mcycle_hi_r + {31'd0, mcycle_carry_s};
    end
  end

  // Trap-related state: mstatus, mepc, mcause (reset > irq > mret > write)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mepc_r         <= {(XLEN-2){1'b0}};
      mcause_r       <= {XLEN{1'b0}};
    end else if (irq_s) begin
      mepc_r         <= pc[XLEN-1:2];
      mcause_r       <= MCAUSE_MTI;
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
    end else if (mret_s) begin
      mstatus_mie_r  <= mstatus_mpie_r;
      mstatus_mpie_r <= 1'b1;
    end else begin
      if (we_mstatus_s) begin
        mstatus_mie_r  <= wdata_s[BIT_MIE];
        mstatus_mpie_r <= wdata_s[BIT_MPIE];
      end
      if (we_mepc_s) begin
        mepc_r <= wdata_s[XLEN-1:2];
      end
      if (we_mcause_s) begin
        mcause_r <= wdata_s;
      end
    end
  end

  // Plain software-written registers: mie, mtvec, mscratch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_mtie_r <= 1'b0;
      mtvec_r    <= MTVEC_RST;
      mscratch_r <= {XLEN{1'b0}};
    end else begin
      if (we_mie_s) begin
        mie_mtie_r <= wdata_s[BIT_MTIE];
      end
      if (we_mtvec_s) begin
        mtvec_r <= wdata_s;
      end
      if (we_mscratch_s) begin
        mscratch_r <= wdata_s;
      end
    end
  end

  // Free-running 64-bit cycle counter; keeps counting through trap cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_lo_r <= {XLEN{1'b0}};
      mcycle_hi_r <= {XLEN{1'b0}};
    end else begin
      mcycle_lo_r <= mcycle_lo_next_s;
      mcycle_hi_r <= mcycle_hi_next_s;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

  localparam logic [31:0] TB_MTVEC_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_rd;
  logic        csr_wr;
  logic [31:0] inst;
  logic [31:0] rs1_data;
  logic [31:0] pc;
  logic        timer_irq;
  logic        is_mret;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] epc;

  always #5 clk = ~clk;

  csr_file #(.MTVEC_RST(TB_MTVEC_RST), .XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .csr_rd    (csr_rd),
    .csr_wr    (csr_wr),
    .inst      (inst),
    .rs1_data  (rs1_data),
    .pc        (pc),
    .timer_irq (timer_irq),
    .is_mret   (is_mret),
    .csr_rdata (csr_rdata),
    .epc_taken (epc_taken),
    .epc       (epc)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: architectural CSR values as whole words
  logic [31:0]     m_mstatus;
  logic [31:0]     m_mie;
  logic [31:0]     m_mtvec;
  logic [31:0]     m_mscratch;
  logic [31:0]     m_mepc;
  logic [31:0]     m_mcause;
  longint unsigned m_cycle;

  typedef struct {
    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic        irq;
    logic        mret;
    logic [31:0] e_rdata;
    logic        e_taken;
    logic [31:0] e_epc;
  } vec_t;

  vec_t vecs[$];

  logic [11:0] addr_pool [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h344, 12'hB00, 12'hB80, 12'h7C0};

  function automatic logic [31:0] mk(input logic [11:0] a, input logic [4:0] z,
                                     input logic [2:0] f3);
    return {a, z, f3, 5'd1, 7'h73};
  endfunction

  function automatic void add(input logic r, input logic rd, input logic wr,
                              input logic [31:0] in, input logic [31:0] rs1,
                              input logic [31:0] p, input logic irq, input logic mr,
                              input logic [31:0] er, input logic et,
                              input logic [31:0] ee);
    vec_t v;
    v.rst_n = r;  v.rd = rd;  v.wr = wr;  v.inst = in;  v.rs1 = rs1;
    v.pc = p;  v.irq = irq;  v.mret = mr;
    v.e_rdata = er;  v.e_taken = et;  v.e_epc = ee;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a, input logic tirq);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc & 32'hFFFF_FFFC;
      12'h342: return m_mcause;
      12'h344: return tirq ? 32'h0000_0080 : 32'h0000_0000;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      default: return 32'h0000_0000;
    endcase
  endfunction

  // One clock cycle: inputs are already driven. Outputs are compared on the
  // falling edge against the model (and optionally a table entry), then the
  // model advances together with the DUT on the rising edge.
  task automatic step(input string tag, input logic chk_tab, input logic [31:0] t_rdata,
                      input logic t_taken, input logic [31:0] t_epc);
    logic            irq_m;
    logic            mret_m;
    logic [31:0]     e_rdata;
    logic            e_taken;
    logic [31:0]     e_epc;
    logic [11:0]     a;
    logic [4:0]      z;
    logic [2:0]      f3;
    logic [31:0]     src;
    logic [31:0]     oldv;
    logic [31:0]     nv;
    logic            doit;
    logic [31:0]     n_mstatus, n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause;
    longint unsigned n_cycle;

    @(negedge clk);
    a  = inst[31:20];
    z  = inst[19:15];
    f3 = inst[14:12];
    irq_m   = timer_irq && m_mstatus[3] && m_mie[7];
    mret_m  = is_mret && !irq_m;
    e_rdata = csr_rd ? model_read(a, timer_irq) : 32'h0;
    e_taken = irq_m || mret_m;
    if (irq_m) e_epc = (m_mtvec[1:0] == 2'b01) ? (m_mtvec & 32'hFFFF_FFFC) + 32'd28
                                               : (m_mtvec & 32'hFFFF_FFFC);
    else       e_epc = m_mepc & 32'hFFFF_FFFC;

    check({tag, " rdata"}, csr_rdata, e_rdata);
    check({tag, " taken"}, {31'd0, epc_taken}, {31'd0, e_taken});
    if (e_taken) check({tag, " epc"}, epc, e_epc);
    if (chk_tab) begin
      check({tag, " tab_rdata"}, csr_rdata, t_rdata);
      check({tag, " tab_taken"}, {31'd0, epc_taken}, {31'd0, t_taken});
      if (t_taken) check({tag, " tab_epc"}, epc, t_epc);
    end

    n_mstatus = m_mstatus;  n_mie = m_mie;  n_mtvec = m_mtvec;
    n_mscratch = m_mscratch;  n_mepc = m_mepc;  n_mcause = m_mcause;
    n_cycle = m_cycle + 64'd1;

    src  = f3[2] ? {27'd0, z} : rs1_data;
    oldv = model_read(a, timer_irq);
    doit = 1'b0;
    nv   = oldv;
    case (f3[1:0])
      2'b01:   begin doit = 1'b1;          nv = src;          end
      2'b10:   begin doit = (z != 5'd0);   nv = oldv | src;   end
      2'b11:   begin doit = (z != 5'd0);   nv = oldv & ~src;  end
      default: begin doit = 1'b0;          nv = oldv;         end
    endcase

    if (!rst_n) begin
      n_mstatus = 32'h0;  n_mie = 32'h0;  n_mtvec = TB_MTVEC_RST;
      n_mscratch = 32'h0;  n_mepc = 32'h0;  n_mcause = 32'h0;  n_cycle = 64'd0;
    end else if (irq_m) begin
      n_mepc    = pc;
      n_mcause  = 32'h8000_0007;
      n_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    end else if (mret_m) begin
      n_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else if (csr_wr && doit) begin
      case (a)
        12'h300: n_mstatus  = nv & 32'h0000_0088;
        12'h304: n_mie      = nv & 32'h0000_0080;
        12'h305: n_mtvec    = nv;
        12'h340: n_mscratch = nv;
        12'h341: n_mepc     = nv & 32'hFFFF_FFFC;
        12'h342: n_mcause   = nv;
        12'hB00: n_cycle    = (n_cycle & 64'hFFFF_FFFF_0000_0000) | {32'd0, nv};
        12'hB80: n_cycle    = (n_cycle & 64'h0000_0000_FFFF_FFFF) | {nv, 32'd0};
        default: ;
      endcase
    end

    @(posedge clk);
    m_mstatus = n_mstatus;  m_mie = n_mie;  m_mtvec = n_mtvec;
    m_mscratch = n_mscratch;  m_mepc = n_mepc;  m_mcause = n_mcause;
    m_cycle = n_cycle;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;  csr_rd = 1'b0;  csr_wr = 1'b0;  inst = 32'h0;  rs1_data = 32'h0;
    pc = 32'h0;  timer_irq = 1'b0;  is_mret = 1'b0;
    m_mstatus = 32'h0;  m_mie = 32'h0;  m_mtvec = TB_MTVEC_RST;  m_mscratch = 32'h0;
    m_mepc = 32'h0;  m_mcause = 32'h0;  m_cycle = 64'd0;

    // Directed table (rows are consecutive cycles)
    add(0,0,0, 32'h0, 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(0,0,0, 32'h0, 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 10; i++) add(1,0,0, 32'h0, 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,0, mk(12'hB00,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'd10, 0, 32'h0);
    add(1,1,0, mk(12'h300,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,0, mk(12'h304,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,0, mk(12'h341,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    // mscratch RW / RS / RC-with-x0
    add(1,1,1, mk(12'h340,5'd1,3'b001), 32'hDEAD_BEEF, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,1, mk(12'h340,5'd2,3'b010), 32'h0000_0F00, 32'h0, 0,0, 32'hDEAD_BEEF, 0, 32'h0);
    add(1,1,1, mk(12'h340,5'd0,3'b011), 32'hFFFF_FFFF, 32'h0, 0,0, 32'hDEAD_BFEF, 0, 32'h0);
    add(1,1,0, mk(12'h340,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'hDEAD_BFEF, 0, 32'h0);
    // vectored trap entry with a concurrent (dropped) mscratch write
    add(1,1,1, mk(12'h305,5'd1,3'b001), 32'h0000_1001, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,1, mk(12'h300,5'd8,3'b110), 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,1, mk(12'h304,5'd1,3'b010), 32'h0000_0080, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,1, mk(12'h340,5'd1,3'b001), 32'h1234_5678, 32'h200, 1,0, 32'hDEAD_BFEF, 1, 32'h101C);
    add(1,1,0, mk(12'h341,5'd0,3'b010), 32'h0, 32'h0, 1,0, 32'h200, 0, 32'h0);
    add(1,1,0, mk(12'h342,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h8000_0007, 0, 32'h0);
    add(1,1,0, mk(12'h300,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h80, 0, 32'h0);
    add(1,1,0, mk(12'h340,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'hDEAD_BFEF, 0, 32'h0);
    // mret
    add(1,0,0, 32'h0, 32'h0, 32'h0, 0,1, 32'h0, 1, 32'h200);
    add(1,1,0, mk(12'h300,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h88, 0, 32'h0);
    // mcycle low-word wrap carries into the high word
    add(1,1,0, mk(12'hB80,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,0,1, mk(12'hB00,5'd1,3'b001), 32'hFFFF_FFFF, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,0, mk(12'hB00,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'hFFFF_FFFF, 0, 32'h0);
    add(1,1,0, mk(12'hB00,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,0, mk(12'hB80,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h1, 0, 32'h0);
    // mip is read-only; pending irq with MIE=0 does not redirect
    add(1,1,1, mk(12'h300,5'd8,3'b111), 32'h0, 32'h0, 0,0, 32'h88, 0, 32'h0);
    add(1,1,0, mk(12'h344,5'd0,3'b010), 32'h0, 32'h0, 1,0, 32'h80, 0, 32'h0);
    add(1,1,1, mk(12'h344,5'd1,3'b001), 32'h0, 32'h0, 1,0, 32'h80, 0, 32'h0);
    add(1,1,0, mk(12'h344,5'd0,3'b010), 32'h0, 32'h0, 1,0, 32'h80, 0, 32'h0);
    add(1,1,0, mk(12'h344,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    // unimplemented address
    add(1,1,1, mk(12'h7C0,5'd1,3'b001), 32'hFFFF_FFFF, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,0, mk(12'h7C0,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    // mtvec mode 11 behaves as direct
    add(1,1,1, mk(12'h305,5'd1,3'b001), 32'h0000_2003, 32'h0, 0,0, 32'h1001, 0, 32'h0);
    add(1,1,1, mk(12'h300,5'd8,3'b110), 32'h0, 32'h0, 0,0, 32'h80, 0, 32'h0);
    add(1,0,0, 32'h0, 32'h0, 32'h400, 1,0, 32'h0, 1, 32'h2000);
    // reset arriving in a trap cycle wins
    add(1,1,1, mk(12'h300,5'd8,3'b110), 32'h0, 32'h0, 0,0, 32'h80, 0, 32'h0);
    add(0,0,0, 32'h0, 32'h0, 32'h800, 1,0, 32'h0, 1, 32'h2000);
    add(1,1,0, mk(12'h341,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,0, mk(12'h342,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'h0, 0, 32'h0);
    add(1,1,0, mk(12'h305,5'd0,3'b010), 32'h0, 32'h0, 0,0, TB_MTVEC_RST, 0, 32'h0);
    add(1,1,0, mk(12'hB00,5'd0,3'b010), 32'h0, 32'h0, 0,0, 32'd3, 0, 32'h0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;  csr_rd = vecs[i].rd;  csr_wr = vecs[i].wr;
      inst = vecs[i].inst;  rs1_data = vecs[i].rs1;  pc = vecs[i].pc;
      timer_irq = vecs[i].irq;  is_mret = vecs[i].mret;
      step($sformatf("row%0d", i), 1'b1, vecs[i].e_rdata, vecs[i].e_taken, vecs[i].e_epc);
    end

    // Hand sequence: writing mcycleh holds the written value for a cycle
    rst_n = 1'b1;  timer_irq = 1'b0;  is_mret = 1'b0;
    csr_rd = 1'b0;  csr_wr = 1'b1;  inst = mk(12'hB80, 5'd1, 3'b001);  rs1_data = 32'h55;
    step("hi_wr", 1'b0, 32'h0, 1'b0, 32'h0);
    csr_rd = 1'b1;  csr_wr = 1'b0;  inst = mk(12'hB80, 5'd0, 3'b010);
    step("hi_rd", 1'b1, 32'h55, 1'b0, 32'h0);

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      csr_rd    = ($urandom_range(0, 3) != 0);
      csr_wr    = ($urandom_range(0, 2) != 0);
      inst      = mk(addr_pool[$urandom_range(0, 9)],
                     ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                     3'($urandom_range(0, 7)));
      rs1_data  = $urandom;
      pc        = $urandom;
      timer_irq = ($urandom_range(0, 5) == 0);
      is_mret   = ($urandom_range(0, 11) == 0);
      step($sformatf("rnd%0d", i), 1'b0, 32'h0, 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
Machine-mode CSR register file. It is the responder to the decoder's csr_rd/csr_wr strobes in the single-cycle core.
- Serves Zicsr read-modify-write instructions.
- Runs the free-running mcycle counter.
- Takes machine timer interrupts and executes mret.
- Returns the read value for the wb_sel=11 write-back path and a PC redirect (epc_taken/epc) to the fetch stage.

Parameters:
MTVEC_RST, 32'h0000_0000, reset value of mtvec
XLEN, 32, data width; only 32 is supported

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
csr_rd  in  1  decoder strobe: current instruction reads a CSR
csr_wr  in  1  decoder strobe: current instruction may write a CSR
inst  in  32  current instruction; uses [31:20] csr address, [19:15] rs1/zimm, [14:12] func3
rs1_data  in  32  register-file rs1 value
pc  in  32  PC of the instruction executing this cycle
timer_irq  in  1  level machine timer interrupt request
is_mret  in  1  current instruction is mret
csr_rdata  out  32  CSR old value for write-back (combinational)
epc_taken  out  1  redirect fetch this cycle (combinational)
epc  out  32  redirect target (combinational)

Behaviour:
- Reset: synchronous on posedge clk when rst_n=0.
  - mstatus, mie, mepc, mcause, mscratch, mcycle are all cleared to 0.
  - mtvec resets to MTIE_RST... specifically MTVEC_RST.
  - Outputs follow from these values: csr_rdata=0 when no read, epc_taken=0 when timer_irq=0.
- Implemented addresses:
  - 0x300 mstatus: only MIE[3] and MPIE[7] are writable; all other bits read 0.
  - 0x304 mie: only MTIE[7] is writable.
  - 0x305 mtvec: all bits writable. [1:0]=00 selects direct mode; 01 selects vectored mode; values 10/11 are treated as direct.
  - 0x340 mscratch.
  - 0x341 mepc: bits [1:0] always read 0.
  - 0x342 mcause.
  - 0x344 mip: read-only; MTIP[7]=timer_irq; writes ignored.
  - 0xB00 mcycle low word; 0xB80 mcycleh high word.
  - Any other address: reads 0, writes ignored, no exception raised.
- Read: csr_rdata = pre-update value of the addressed CSR when csr_rd=1, else 0. Zero-latency, combinational.
- Write: takes effect at the posedge ending the cycle; new value is visible next cycle. Operand src is rs1_data when func3[2]=0, otherwise zero-extended inst[19:15].
  - 001 / 101 (RW): new = src.
  - 010 / 110 (RS): new = old | src.
  - 011 / 111 (RC): new = old & ~src.
  - RS and RC with inst[19:15]=0 perform no write. RW always writes.
  - func3=000 or 100: no write.
- mcycle: 64-bit counter, increments by 1 every cycle when not in reset, with carry from low to high word.
  - A write to 0xB00 or 0xB80 in a cycle replaces that half with the written value; there is no increment of that half that cycle.
  - The other half still updates normally, including carry.
  - Wrap from 0xFFFF_FFFF_FFFF_FFFF goes to 0.
- Interrupt take (irq = timer_irq & mstatus.MIE & mie.MTIE), in the same cycle:
  - epc_taken=1.
  - epc = {mtvec[31:2],2'b00} in direct mode; that base + 28 in vectored mode (cause 7).
  - At the posedge: mepc<=pc, mcause<=32'h8000_0007, MPIE<=MIE, MIE<=0.
  - The interrupted instruction is not retired: its CSR write is suppressed, and it re-executes after mret.
- mret (is_mret=1 and irq=0), in the same cycle:
  - epc_taken=1, epc=mepc.
  - At the posedge: MIE<=MPIE, MPIE<=1.
- Priority: reset > irq > mret > CSR write. mcycle still increments during a trap cycle.
- Once taken, the trap sets MIE=0, so a held timer_irq does not re-trap until software re-enables MIE.
- Reset asserted mid-trap: reset wins. mepc and mcause are cleared, with no partial update.

Test Plan:
- Reset, then idle 10 cycles -> read 0xB00 returns 10 (±0 by exact count from reset release); mstatus/mie/mepc read 0; epc_taken=0.
- CSRRW 0x340 with rs1_data=0xDEADBEEF, then CSRRS 0x340 with rs1_data=0x0000_0F00 -> second read returns 0xDEADBEEF; mscratch becomes 0xDEADBFEF. CSRRC with inst[19:15]=0 leaves the value unchanged.
- mtvec=0x0000_1001 (vectored), MIE=1, MTIE=1, pc=0x200, timer_irq=1 -> epc_taken=1, epc=0x101C. Next cycle: mepc=0x200, mcause=0x8000_0007, mstatus=0x80. A concurrent CSRRW to mscratch is dropped.
- After the trap, is_mret=1 with timer_irq=0 -> epc=0x200; mstatus returns to 0x88.
- CSRRW 0xB00=0xFFFF_FFFF, then 1 cycle -> mcycle low=0, high incremented by 1.
- timer_irq=1 with MIE=0 -> no redirect; read 0x344 returns 0x80; CSRRW 0x344=0 leaves mip unchanged.
